// File: rtl/id_ex_multi_pkg.sv
// rtl/id_ex_multi_pkg.sv - shared types and defaults for the multi-issue ID/EX buffer
//
// Purpose : lane payload layout, bundle type, default issue width / depth and
//           a pointer-width helper used by the buffer.
// Ports   : none (package).
package id_ex_multi_pkg;

  localparam int ID_EX_LANES_DEF = 2;
  localparam int ID_EX_DEPTH_DEF = 2;

  // One decode slot as handed from decode to execute.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [15:0] exop;
    logic [7:0]  waddr;
    logic [7:0]  except;
  } id_ex_lane_t;

  localparam int ID_EX_DATA_W = $bits(id_ex_lane_t);

  typedef id_ex_lane_t [ID_EX_LANES_DEF-1:0] id_ex_bundle_t;

  // A one-entry buffer still needs a 1-bit pointer to keep widths legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_ex_multi_bundle_fifo.sv
// rtl/id_ex_multi_bundle_fifo.sv - DEPTH x bundle circular buffer with async reset
//
// Purpose : stores bundles (per-lane valid + payload) in FIFO order.
// Ports   : clk, rst            - clock, async active-high reset
//           clr                 - synchronous clear of pointers, count, lane valids
//           push, wr_lv, wr_data- write a bundle (caller guarantees not full)
//           pop                 - retire the head (caller guarantees not empty)
//           rd_lv, rd_data      - head entry, raw (not masked when empty)
//           count               - number of stored bundles
module bundle_fifo
  import id_ex_multi_pkg::*;
#(
  parameter int LANES  = ID_EX_LANES_DEF,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int DEPTH  = ID_EX_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [LANES-1:0]           wr_lv,
  input  logic [LANES*DATA_W-1:0]    wr_data,
  input  logic                       pop,
  output logic [LANES-1:0]           rd_lv,
  output logic [LANES*DATA_W-1:0]    rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [LANES-1:0]        lv_q   [DEPTH];
  logic [LANES*DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = nxt(wr_ptr_q);
      if (pop)  rd_ptr_d = nxt(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) lv_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) lv_q[i] <= '0;
      end else if (push) begin
        lv_q[wr_ptr_q] <= wr_lv;
      end
    end
  end

  // Payload needs no reset: it is only visible while its entry is counted.
  always_ff @(posedge clk) begin
    if (push && !clr) data_q[wr_ptr_q] <= wr_data;
  end

  assign rd_lv   = lv_q[rd_ptr_q];
  assign rd_data = data_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/id_ex_multi.sv
// rtl/id_ex_multi.sv - elastic multi-issue ID/EX stage with delay-slot ring-back
//
// Purpose : buffers up to DEPTH bundles of LANES decode slots between decode
//           and execute using valid/ready, with flush-to-bubble and the
//           delay-slot flag fed back to decode.
// Ports   : clk, rst                  - clock, async active-high reset
//           flush                     - drop everything, clear delay-slot flag
//           in_valid/in_ready         - decode-side handshake
//           in_lane_valid, in_data    - incoming bundle (lane 0 in LSBs)
//           in_next_ds, ds_hold       - delay-slot flag control
//           out_valid/out_ready       - execute-side handshake
//           out_lane_valid, out_data  - head bundle, zero when empty
//           id_in_delayslot           - next accepted bundle sits in a delay slot
//           occupancy                 - buffered bundle count
module id_ex_multi
  import id_ex_multi_pkg::*;
#(
  parameter int LANES  = ID_EX_LANES_DEF,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int DEPTH  = ID_EX_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic                       in_next_ds,
  input  logic                       ds_hold,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic                       id_in_delayslot,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]        count;
  logic [LANES-1:0]        head_lv;
  logic [LANES*DATA_W-1:0] head_data;
  logic                    push, pop;
  logic                    ds_q, ds_d;

  // in_ready depends on registered count only, so out_ready never ripples
  // back into decode; a pop while full frees the slot one cycle later.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  bundle_fifo #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push),
    .wr_lv   (in_lane_valid),
    .wr_data (in_data),
    .pop     (pop),
    .rd_lv   (head_lv),
    .rd_data (head_data),
    .count   (count)
  );

  // Empty buffer presents an all-zero bundle, which EX treats as a NOP.
  assign out_lane_valid = out_valid ? head_lv   : '0;
  assign out_data       = out_valid ? head_data : '0;
  assign occupancy      = count;

  always_comb begin
    ds_d = ds_q;
    if (flush) begin
      ds_d = 1'b0;
    end else if (push) begin
      ds_d = (ds_hold & ds_q) ? ds_q : in_next_ds;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ds_q <= 1'b0;
    else     ds_q <= ds_d;
  end

  assign id_in_delayslot = ds_q;

endmodule

// File: tb/tb_id_ex_multi.sv
// tb/tb_id_ex_multi.sv - self-checking bench for id_ex_multi
module tb_id_ex_multi;

  localparam int LANES  = 2;
  localparam int DATA_W = 160;
  localparam int DEPTH  = 2;
  localparam int BW     = LANES * DATA_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LANES-1:0] in_lane_valid = '0;
  logic [BW-1:0]   in_data = '0;
  logic            in_next_ds = 1'b0;
  logic            ds_hold = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LANES-1:0] out_lane_valid;
  logic [BW-1:0]   out_data;
  logic            id_in_delayslot;
  logic [1:0]      occupancy;

  id_ex_multi #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_lane_valid   (in_lane_valid),
    .in_data         (in_data),
    .in_next_ds      (in_next_ds),
    .ds_hold         (ds_hold),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_lane_valid  (out_lane_valid),
    .out_data        (out_data),
    .id_in_delayslot (id_in_delayslot),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] lv;
    logic [BW-1:0]    d;
  } bundle_t;

  bundle_t m_q[$];
  logic    m_ds = 1'b0;
  int      n_chk = 0;
  int      n_fail = 0;
  int      n_out = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, BW'(out_valid), BW'(m_q.size() != 0));
    check({tag, ".out_lv"}, BW'(out_lane_valid), (m_q.size() != 0) ? BW'(m_q[0].lv) : '0);
    check({tag, ".out_data"}, out_data, (m_q.size() != 0) ? m_q[0].d : '0);
    check({tag, ".in_ready"}, BW'(in_ready), BW'(m_q.size() < DEPTH));
    check({tag, ".occupancy"}, BW'(occupancy), BW'(m_q.size()));
    check({tag, ".ds"}, BW'(id_in_delayslot), BW'(m_ds));
  endtask

  // Advance one clock: update the reference from the rules, then compare.
  task automatic step(input string tag);
    bit rdy, pu, po;
    bundle_t b;
    rdy = (m_q.size() < DEPTH);
    pu  = in_valid && rdy && !flush;
    po  = (m_q.size() != 0) && out_ready && !flush;
    if (flush) begin
      m_q.delete();
      m_ds = 1'b0;
    end else begin
      if (po) begin
        void'(m_q.pop_front());
        n_out++;
      end
      if (pu) begin
        b.lv = in_lane_valid;
        b.d  = in_data;
        m_q.push_back(b);
        if (!(ds_hold && m_ds)) m_ds = in_next_ds;
      end
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  function automatic logic [BW-1:0] mk(input logic [31:0] pc0);
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    v[31:0]           = pc0;
    v[DATA_W +: 32]   = pc0 + 32'd4;
    return v;
  endfunction

  task automatic drive(input bit v, input logic [LANES-1:0] lv, input logic [31:0] pc0);
    in_valid      = v;
    in_lane_valid = lv;
    in_data       = mk(pc0);
  endtask

  logic [BW-1:0] dropped;
  bit            seen;

  initial begin
    // Reset state
    #2;
    check("rst.out_valid", BW'(out_valid), '0);
    check("rst.in_ready", BW'(in_ready), BW'(1));
    check("rst.out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    step("idle");

    // Reset mid-stream: two bundles buffered then async reset between edges
    out_ready = 1'b0;
    in_next_ds = 1'b1;
    drive(1, 2'b11, 32'h200); step("mrs.p1");
    in_next_ds = 1'b0;
    drive(1, 2'b11, 32'h208); step("mrs.p2");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_q.delete();
    m_ds = 1'b0;
    check("mrs.out_valid", BW'(out_valid), '0);
    check("mrs.occupancy", BW'(occupancy), '0);
    check("mrs.ds", BW'(id_in_delayslot), '0);
    check("mrs.in_ready", BW'(in_ready), BW'(1));
    @(negedge clk);
    rst = 1'b0;
    step("mrs.after");

    // Back-pressure
    drive(1, 2'b11, 32'h100); step("bp.a");
    drive(1, 2'b11, 32'h108); step("bp.b");
    check("bp.in_ready_full", BW'(in_ready), '0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("bp.pop");
    check("bp.head_pc", BW'(out_data[31:0]), BW'(32'h108));
    check("bp.head_pc1", BW'(out_data[DATA_W +: 32]), BW'(32'h10C));
    check("bp.occ1", BW'(occupancy), BW'(1));
    out_ready = 1'b1;
    step("bp.drain");

    // Full throughput from empty: 8 bundles back to back
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b11, 32'h1000 + 32'(i) * 8);
      step("thr");
      check("thr.no_bubble", BW'(out_valid), BW'(1));
    end
    in_valid = 1'b0;
    step("thr.last");
    check("thr.count", BW'(n_out), BW'(8));

    // Flush versus simultaneous push
    out_ready = 1'b0;
    drive(1, 2'b11, 32'h300); step("fl.fill");
    check("fl.occ1", BW'(occupancy), BW'(1));
    in_next_ds = 1'b1;
    drive(1, 2'b11, 32'h308);
    dropped = in_data;
    flush = 1'b1;
    step("fl.flush");
    flush = 1'b0;
    in_next_ds = 1'b0;
    check("fl.occ0", BW'(occupancy), '0);
    check("fl.data0", out_data, '0);
    check("fl.ds0", BW'(id_in_delayslot), '0);
    check("fl.in_ready", BW'(in_ready), BW'(1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("fl.watch");
      if (out_valid && out_data === dropped) seen = 1'b1;
    end
    check("fl.not_seen", BW'(seen), '0);

    // Delay-slot hold
    in_next_ds = 1'b1; ds_hold = 1'b0;
    drive(1, 2'b01, 32'h400); step("ds.set");
    check("ds.set1", BW'(id_in_delayslot), BW'(1));
    in_next_ds = 1'b0; ds_hold = 1'b1;
    drive(1, 2'b01, 32'h408); step("ds.hold");
    check("ds.held1", BW'(id_in_delayslot), BW'(1));
    ds_hold = 1'b0;
    drive(1, 2'b01, 32'h410); step("ds.clr");
    check("ds.clr0", BW'(id_in_delayslot), '0);
    in_valid = 1'b0;
    step("ds.drain");
    step("ds.drain2");

    // Partial bundle and explicit bubble
    out_ready = 1'b0;
    drive(1, 2'b01, 32'h500); step("pb.01");
    drive(1, 2'b00, 32'h508); step("pb.00");
    check("pb.occ2", BW'(occupancy), BW'(2));
    check("pb.head01", BW'(out_lane_valid), BW'(2'b01));
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("pb.pop1");
    check("pb.head00", BW'(out_lane_valid), BW'(2'b00));
    check("pb.valid", BW'(out_valid), BW'(1));
    step("pb.pop2");

    // Randomised traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid      = ($urandom_range(0, 3) != 0);
        in_lane_valid = LANES'($urandom);
        in_data       = mk($urandom);
        in_next_ds    = $urandom_range(0, 1);
        ds_hold       = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
